// File: rtl/inst_fetch_if.sv
// inst_fetch_if: bundles the fetch-stage signals of inst_fetch.
//   Request side : i_addr, addr_vld (in), addr_rdy (out), flush (in)
//   ROM side     : mem_en, mem_addr (out), mem_rdata (in)
//   Decode side  : o_inst, o_pc, o_vld, o_mis (out), i_rdy (in)
// The slave modport is the fetch stage; master is whatever drives it
// (PC generator, ROM and decode, or a testbench standing in for them).
interface inst_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] i_addr;
    logic              addr_vld;
    logic              addr_rdy;
    logic              flush;
    logic              mem_en;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] o_inst;
    logic [ADDR_W-1:0] o_pc;
    logic              o_vld;
    logic              i_rdy;
    logic              o_mis;

    modport slave (
        input  i_addr, addr_vld, flush, mem_rdata, i_rdy,
        output addr_rdy, mem_en, mem_addr, o_inst, o_pc, o_vld, o_mis
    );

    modport master (
        output i_addr, addr_vld, flush, mem_rdata, i_rdy,
        input  addr_rdy, mem_en, mem_addr, o_inst, o_pc, o_vld, o_mis
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage behind the program counter.
// Accepts byte addresses, issues word reads to a 1-cycle-latency ROM,
// buffers {pc, instruction} in a DEPTH-entry FIFO and hands the head to
// decode over valid/ready. flush drops buffered and in-flight fetches.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : inst_fetch_if.slave (request, ROM and decode signals)
module inst_fetch #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_fetch_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              mis_q, mis_d;
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [DATA_W-1:0] inst_d [DEPTH];

    logic [PTR_W-1:0]  occ;
    logic [CNT_W-1:0]  cnt;
    logic              empty;
    logic              addr_rdy;
    logic              acc;
    logic              push;
    logic              pop;
    logic              o_vld;

    // Pointers wrap modulo 2*DEPTH, so the plain difference is the occupancy.
    assign occ   = wr_ptr_q - rd_ptr_q;
    // In-flight data holds a credit so a push can never find the FIFO full.
    assign cnt   = {1'b0, occ} + CNT_W'(pend_q);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign addr_rdy = (cnt < CNT_W'(DEPTH)) & ~bus.flush;
    assign acc      = bus.addr_vld & addr_rdy;
    assign push     = pend_q & ~bus.flush;
    assign o_vld    = ~empty & ~bus.flush;
    assign pop      = o_vld & bus.i_rdy;

    assign bus.addr_rdy = addr_rdy;
    // Keep the ROM quiet while reset is held, whatever the request inputs do.
    assign bus.mem_en   = acc & rst_n;
    assign bus.mem_addr = bus.i_addr[ADDR_W-1:2];
    assign bus.o_vld    = o_vld;
    assign bus.o_inst   = inst_q[rd_ptr_q[IDX_W-1:0]];
    assign bus.o_pc     = pc_q[rd_ptr_q[IDX_W-1:0]];
    assign bus.o_mis    = mis_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pend_d    = acc;
        pend_pc_d = acc ? bus.i_addr : pend_pc_q;
        mis_d     = mis_q | (acc & (bus.i_addr[1:0] != 2'b00));
        pc_d      = pc_q;
        inst_d    = inst_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pend_d   = 1'b0;
        end else begin
            if (push) begin
                pc_d[wr_ptr_q[IDX_W-1:0]]   = pend_pc_q;
                inst_d[wr_ptr_q[IDX_W-1:0]] = bus.mem_rdata;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            mis_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            mis_q     <= mis_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
        end
    end
endmodule
